// File: rtl/data_step_sequencer_if.sv
// rtl/data_step_sequencer_if.sv - command handshake bundle between instruction sequencer and data_step_sequencer
interface data_step_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic [9:0]       cmd_data;

   modport master (output cmd_valid, cmd_op, cmd_count, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_count, cmd_data, output cmd_ready);
endinterface

// File: rtl/data_step_sequencer.sv
// rtl/data_step_sequencer.sv - expands inc/dec/load/clear commands into timed dekatron Step/Reverse/Set/In sequences
// Optional SATURATE_EN: stop inc at BCD 255 and dec at 0 instead of letting the counter wrap.
module data_step_sequencer #(
   parameter int STEP_W   = 4,
   parameter int SETTLE_W = 8,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_step_sequencer_if.slave cmd,
   output logic                 step,
   output logic                 reverse,
   output logic                 set,
   output logic [9:0]           in,
   input  logic [9:0]           out,
   output logic                 busy,
   output logic                 done,
   output logic                 zero
);
   localparam int TMR_MAX = (STEP_W > SETTLE_W) ? STEP_W : SETTLE_W;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] STEP_LD   = TMR_W'(STEP_W - 1);
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_W - 1);
   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, FINISH} state_t;

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [9:0]       data_q;
   logic [CNT_W-1:0] rem_q;
   logic [TMR_W-1:0] tmr_q;
   logic             init_q;
   logic             zero_q;
   logic             accept;
   logic             more_steps;
   logic             sat_hit;
   logic             active;

   // Ready is held low until the first clock after reset release.
   assign cmd.cmd_ready = init_q && (state == IDLE);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign more_steps    = (rem_q > CNT_W'(1));

`ifdef SATURATE_EN
   logic [1:0] chk_op;

   // At accept the op is not yet latched, so check against the incoming one.
   assign chk_op = (state == IDLE) ? cmd.cmd_op : op_q;

   always_comb begin
      sat_hit = 1'b0;
      if (chk_op == OP_INC)
         sat_hit = (out == 10'h255);
      else if (chk_op == OP_DEC)
         sat_hit = (out == 10'h000);
   end
`else
   assign sat_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      active    = 1'b0;
      step      = 1'b0;
      reverse   = 1'b0;
      set       = 1'b0;
      in        = '0;
      busy      = (state != IDLE);
      done      = (state == FINISH);
      zero      = zero_q;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cmd.cmd_op[1])
                  state_nxt = SETUP;
               else if ((cmd.cmd_count == '0) || sat_hit)
                  state_nxt = FINISH;
               else
                  state_nxt = SETUP;
            end
         end
         SETUP:   state_nxt = PULSE;
         PULSE:   if (tmr_q == '0) state_nxt = SETTLE;
         SETTLE:  if (tmr_q == '0) state_nxt = (more_steps && !sat_hit) ? SETUP : FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      active  = (state == SETUP) || (state == PULSE) || (state == SETTLE);
      step    = (state == PULSE);
      reverse = active && (op_q == OP_DEC);
      set     = active && op_q[1];
      in      = set ? data_q : 10'h000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= '0;
         data_q <= '0;
         rem_q  <= '0;
         tmr_q  <= '0;
         init_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         init_q <= 1'b1;
         if (accept) begin
            op_q   <= cmd.cmd_op;
            data_q <= (cmd.cmd_op == OP_LOAD) ? cmd.cmd_data : 10'h000;
            rem_q  <= cmd.cmd_op[1] ? CNT_W'(1) : cmd.cmd_count;
         end
         if ((state_nxt == PULSE) && (state != PULSE))
            tmr_q <= STEP_LD;
         else if ((state_nxt == SETTLE) && (state != SETTLE))
            tmr_q <= SETTLE_LD;
         else if (tmr_q != '0)
            tmr_q <= tmr_q - 1'b1;
         if ((state == SETTLE) && (state_nxt != SETTLE))
            rem_q <= rem_q - CNT_W'(1);
         if (state == FINISH)
            zero_q <= (out == 10'h000);
      end
   end
endmodule

// File: tb/tb_data_step_sequencer.sv
// tb/tb_data_step_sequencer.sv - directed table-driven bench for data_step_sequencer with a dekatron counter model
module tb_data_step_sequencer;
   localparam int STEP_W   = 4;
   localparam int SETTLE_W = 8;
   localparam int STEP_CYC = 1 + STEP_W + SETTLE_W;
   localparam logic [1:0] OP_INC   = 2'b00;
   localparam logic [1:0] OP_DEC   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef struct {
      logic [1:0] op;
      int         count;
      logic [9:0] data;
      int         preset;
      int         pulses;
      logic       rev;
      logic       setv;
      logic [9:0] inv;
      int         done_cyc;
      logic [9:0] fin;
      logic       zero;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       step, reverse, set, busy, done, zero;
   logic [9:0] in;
   logic [9:0] out;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cnt_val = 0;
   logic       step_d = 1'b0;
   logic       preset_req = 1'b0;
   int         preset_val = 0;
   vec_t       vecs[7];

   data_step_sequencer_if #(.CNT_W(8)) cmd_if ();

   data_step_sequencer #(.STEP_W(STEP_W), .SETTLE_W(SETTLE_W), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .step(step), .reverse(reverse), .set(set),
      .in(in), .out(out), .busy(busy), .done(done), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] to_bcd(input int v);
      logic [9:0] r;
      r[9:8] = 2'(v / 100);
      r[7:4] = 4'((v / 10) % 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic int from_bcd(input logic [9:0] b);
      return int'(b[9:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Dekatron counter model: counts on each rising Step, wraps 0..255.
   always @(posedge clk) begin
      step_d <= step;
      if (preset_req)
         cnt_val <= preset_val;
      else if (step && !step_d) begin
         if (set)
            cnt_val <= from_bcd(in);
         else if (reverse)
            cnt_val <= (cnt_val == 0) ? 255 : cnt_val - 1;
         else
            cnt_val <= (cnt_val == 255) ? 0 : cnt_val + 1;
      end
   end
   assign out = to_bcd(cnt_val);

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preset_cnt(input int v);
      @(negedge clk);
      preset_val = v;
      preset_req = 1'b1;
      @(posedge clk);
      #1 preset_req = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input int count, input logic [9:0] data, output bit ok);
      int w;
      @(negedge clk);
      cmd_if.cmd_op    = op;
      cmd_if.cmd_count = 8'(count);
      cmd_if.cmd_data  = data;
      cmd_if.cmd_valid = 1'b1;
      w = 0;
      while (!cmd_if.cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      ok = cmd_if.cmd_ready;
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit   ok;
      int   pulses, first_rise, last_rise, cur_w, bad_w, bad_act, glitch, done_cyc, exp_first, exp_span;
      logic prev_step, prev_rev, prev_set;
      preset_cnt(v.preset);
      issue(v.op, v.count, v.data, ok);
      check($sformatf("v%0d accept", idx), int'(ok), 1);
      pulses = 0; first_rise = -1; last_rise = -1; cur_w = 0; bad_w = 0;
      bad_act = 0; glitch = 0; done_cyc = -1;
      prev_step = 1'b0; prev_rev = reverse; prev_set = set;
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (i == 1 && v.pulses > 0) begin
            check($sformatf("v%0d setup step", idx), int'(step), 0);
            check($sformatf("v%0d setup set", idx), int'(set), int'(v.setv));
            check($sformatf("v%0d setup in", idx), int'(in), int'(v.inv));
            check($sformatf("v%0d setup reverse", idx), int'(reverse), int'(v.rev));
         end
         if (done) begin
            done_cyc = i;
            break;
         end
         if (step && !prev_step) begin
            pulses++;
            if (first_rise < 0) first_rise = i;
            last_rise = i;
         end
         if (step) cur_w++;
         else if (prev_step) begin
            if (cur_w != STEP_W) bad_w++;
            cur_w = 0;
         end
         if (reverse !== v.rev || set !== v.setv || in !== v.inv) bad_act++;
         if (step && (reverse !== prev_rev || set !== prev_set)) glitch++;
         prev_step = step; prev_rev = reverse; prev_set = set;
      end
      exp_first = (v.pulses > 0) ? 2 : -1;
      exp_span  = (v.pulses > 0) ? (v.pulses - 1) * STEP_CYC : 0;
      check($sformatf("v%0d done cycle", idx), done_cyc, v.done_cyc);
      check($sformatf("v%0d pulse count", idx), pulses, v.pulses);
      check($sformatf("v%0d first step cycle", idx), first_rise, exp_first);
      check($sformatf("v%0d step span", idx), last_rise - first_rise, exp_span);
      check($sformatf("v%0d bad pulse widths", idx), bad_w, 0);
      check($sformatf("v%0d rev/set/in held", idx), bad_act, 0);
      check($sformatf("v%0d step during change", idx), glitch, 0);
      check($sformatf("v%0d finish outputs", idx), int'({step, reverse, set, in}), 0);
      @(negedge clk);
      check($sformatf("v%0d final out", idx), int'(out), int'(v.fin));
      check($sformatf("v%0d zero", idx), int'(zero), int'(v.zero));
      check($sformatf("v%0d idle busy", idx), int'(busy), 0);
      check($sformatf("v%0d idle ready", idx), int'(cmd_if.cmd_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      int   hits;
      logic exp_done[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic exp_ready[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      vecs[0] = '{OP_INC,   3, 10'h000,   0, 3, 1'b0, 1'b0, 10'h000, 40, 10'h003, 1'b0};
      vecs[1] = '{OP_LOAD,  0, 10'h128,   0, 1, 1'b0, 1'b1, 10'h128, 14, 10'h128, 1'b0};
`ifdef SATURATE_EN
      vecs[2] = '{OP_DEC,   2, 10'h000,   1, 1, 1'b1, 1'b0, 10'h000, 14, 10'h000, 1'b1};
      vecs[4] = '{OP_INC,   1, 10'h000, 255, 0, 1'b0, 1'b0, 10'h000,  1, 10'h255, 1'b0};
`else
      vecs[2] = '{OP_DEC,   2, 10'h000,   1, 2, 1'b1, 1'b0, 10'h000, 27, 10'h255, 1'b0};
      vecs[4] = '{OP_INC,   1, 10'h000, 255, 1, 1'b0, 1'b0, 10'h000, 14, 10'h000, 1'b1};
`endif
      vecs[3] = '{OP_CLEAR, 7, 10'h3ff, 128, 1, 1'b0, 1'b1, 10'h000, 14, 10'h000, 1'b1};
      vecs[5] = '{OP_LOAD,  0, 10'h099,   0, 1, 1'b0, 1'b1, 10'h099, 14, 10'h099, 1'b0};
      vecs[6] = '{OP_INC,   0, 10'h000,   5, 0, 1'b0, 1'b0, 10'h000,  1, 10'h005, 1'b0};

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_count = 8'd0;
      cmd_if.cmd_data  = 10'h000;

      // Reset held low for three cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", int'({step, reverse, set, in, busy, done, zero}), 0);
      check("reset ready", int'(cmd_if.cmd_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after release", int'(cmd_if.cmd_ready), 1);

      for (int k = 0; k < 7; k++)
         run_vec(vecs[k], k);

      // Zero-count inc with cmd_valid held: the second command waits for ready.
      @(negedge clk);
      cmd_if.cmd_op    = OP_INC;
      cmd_if.cmd_count = 8'd0;
      cmd_if.cmd_valid = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("held c%0d done", c + 1), int'(done), int'(exp_done[c]));
         check($sformatf("held c%0d ready", c + 1), int'(cmd_if.cmd_ready), int'(exp_ready[c]));
         check($sformatf("held c%0d step", c + 1), int'(step), 0);
         if (c == 2) cmd_if.cmd_valid = 1'b0;
      end

      // Reset asserted in the middle of a Step pulse of a five-step inc.
      preset_cnt(0);
      issue(OP_INC, 5, 10'h000, ok);
      check("midreset accept", int'(ok), 1);
      for (int i = 0; i < 20 && !step; i++) @(negedge clk);
      @(negedge clk);
      check("midreset step high", int'(step), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset async outputs", int'({step, reverse, set, in, busy, done}), 0);
      check("midreset ready", int'(cmd_if.cmd_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done || step || busy) hits++;
      end
      check("midreset no activity", hits, 0);
      check("midreset ready after", int'(cmd_if.cmd_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
